// File: rtl/mem_arbiter_rr_pkg.sv
// Shared types for the L1-to-L2 memory arbiter.
// Holds the arbiter FSM encoding and the supported channel ceiling.
package mem_arbiter_rr_pkg;

    localparam int ARB_MAX_CH = 8;

    typedef enum logic {
        ARB_IDLE,
        ARB_BUSY
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational priority search over N request lines. When rr_en is set the
// search starts at ptr and wraps; otherwise the lowest pending index wins.
module rr_priority_picker #(
    parameter int N = 2
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    input  logic                 rr_en,
    output logic                 valid,
    output logic [$clog2(N)-1:0] idx
);
    localparam int IW = $clog2(N);

    logic [IW-1:0] base;
    logic [IW-1:0] lo_idx;
    logic [IW-1:0] hi_idx;
    logic          hi_any;

    assign base  = rr_en ? ptr : '0;
    assign valid = |req;

    // Lowest pending at or above base wins; if none, wrap to lowest pending overall.
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        lo_idx = '0;
        hi_idx = '0;
        hi_any = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_idx = IW'(i);
                if (IW'(i) >= base) begin
                    hi_idx = IW'(i);
                    hi_any = 1'b1;
                end
            end
        end
        idx = hi_any ? hi_idx : lo_idx;
    end

endmodule

// File: rtl/mem_arbiter_rr.sv
// N-channel arbiter between L1 clients and a single L2 memory port.
// Registered grant, one transaction outstanding, fixed or round-robin priority.
module mem_arbiter_rr
    import mem_arbiter_rr_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 128,
    parameter int RR_MODE = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_CH-1:0]          ch_read,
    input  logic [NUM_CH-1:0]          ch_write,
    input  logic [NUM_CH*ADDR_W-1:0]   ch_addr,
    input  logic [NUM_CH*DATA_W-1:0]   ch_wdata,
    output logic [NUM_CH-1:0]          ch_resp,
    output logic [DATA_W-1:0]          ch_rdata,
    output logic                       mem_read,
    output logic                       mem_write,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_wdata,
    input  logic                       mem_resp,
    input  logic [DATA_W-1:0]          mem_rdata,
    output logic                       busy,
    output logic [$clog2(NUM_CH)-1:0]  grant_id
);
    localparam int IW = $clog2(NUM_CH);

    if (NUM_CH < 2 || NUM_CH > ARB_MAX_CH) begin : g_bad_num_ch
        $error("mem_arbiter_rr: NUM_CH out of range");
    end

    arb_state_t        state;
    arb_state_t        state_next;
    logic [IW-1:0]     rr_ptr;
    logic [IW-1:0]     pick_idx;
    logic              pick_valid;
    logic              start;
    logic              done;

    rr_priority_picker #(.N(NUM_CH)) u_picker (
        .req   (ch_read | ch_write),
        .ptr   (rr_ptr),
        .rr_en (RR_MODE != 0),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign start    = (state == ARB_IDLE) && pick_valid;
    assign done     = (state == ARB_BUSY) && mem_resp;
    assign busy     = (state == ARB_BUSY);
    assign ch_rdata = mem_rdata;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ARB_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ARB_IDLE: if (start) state_next = ARB_BUSY;
            ARB_BUSY: if (done)  state_next = ARB_IDLE;
            default:             state_next = ARB_IDLE;
        endcase
    end

    // Request fields are captured at grant; write wins over a simultaneous read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_id  <= '0;
            rr_ptr    <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (start) begin
            grant_id  <= pick_idx;
            mem_write <= ch_write[pick_idx];
            mem_read  <= ~ch_write[pick_idx];
            mem_addr  <= ch_addr[pick_idx*ADDR_W +: ADDR_W];
            mem_wdata <= ch_wdata[pick_idx*DATA_W +: DATA_W];
        end else if (done) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            if (RR_MODE != 0) begin
                rr_ptr <= (grant_id == IW'(NUM_CH - 1)) ? '0 : grant_id + IW'(1);
            end
        end
    end

    always_comb begin
        ch_resp = '0;
        if (done) ch_resp[grant_id] = 1'b1;
    end

endmodule

// File: doc/mem_arbiter_rr.md
Name: mem_arbiter_rr

Overview:
- N-channel arbiter between L1 clients (I-cache, D-cache, future prefetch/DMA) and a single L2/physical memory port.
- Successor to the two-client idle/i_fetch/d_fetch arbiter; generalised to NUM_CH channels.
- Selectable fixed or round-robin priority.
- Registered grant; request address, operation and write data are latched at grant.
- A single memory transaction is outstanding at any time.

Parameters:
- NUM_CH, 2: number of client channels (2..8); channel 0 = I-cache, channel 1 = D-cache.
- ADDR_W, 16: address width.
- DATA_W, 128: cache-line data width.
- RR_MODE, 1: 0 = fixed priority (lowest index wins), 1 = round-robin.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- ch_read  in  NUM_CH  per-channel read request, held until that channel's ch_resp
- ch_write  in  NUM_CH  per-channel write request, held until that channel's ch_resp
- ch_addr  in  NUM_CH*ADDR_W  packed per-channel address; channel i occupies bits [i*ADDR_W +: ADDR_W]
- ch_wdata  in  NUM_CH*DATA_W  packed per-channel write line
- ch_resp  out  NUM_CH  one-hot completion pulse to the granted channel
- ch_rdata  out  DATA_W  read line, broadcast to all channels (valid with ch_resp)
- mem_read  out  1  read strobe to memory
- mem_write  out  1  write strobe to memory
- mem_addr  out  ADDR_W  latched address
- mem_wdata  out  DATA_W  latched write line
- mem_resp  in  1  memory completion
- mem_rdata  in  DATA_W  memory read line
- busy  out  1  transaction outstanding
- grant_id  out  $clog2(NUM_CH)  index of the current or last granted channel

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset values:
  - state = IDLE, rr_ptr = 0, grant_id = 0, busy = 0.
  - mem_read = mem_write = 0; mem_addr and mem_wdata = 0.
  - ch_resp = 0.
- Reset mid-transaction: abandons the transaction immediately and returns to IDLE. No ch_resp is issued.
- A channel is pending when ch_read[i] | ch_write[i] is high.
- IDLE:
  - If any channel is pending, the picker selects winner w.
  - On the clock edge: state goes to BUSY; grant_id <= w.
  - Latched on the same edge: op_write <= ch_write[w]; addr <= ch_addr[w]; wdata <= ch_wdata[w].
  - No memory strobes are driven in IDLE.
  - Arbitration latency: the request is seen in cycle 0 and the memory strobe is asserted from cycle 1.
- BUSY:
  - mem_read = ~op_write and mem_write = op_write, both driven from registers. mem_addr and mem_wdata are held stable.
  - Channel inputs are ignored while BUSY; changes or drops on the granted channel do not alter the memory transaction.
  - On mem_resp:
    - ch_resp[grant_id] = 1 combinationally in the same cycle; ch_rdata = mem_rdata (pass-through, always).
    - Next edge: state goes to IDLE.
    - In RR mode only, rr_ptr <= grant_id+1, wrapping to 0 after NUM_CH-1.
- Minimum spacing between consecutive grants is one IDLE cycle. The finishing client must drop its request on the edge after ch_resp; a request still high in IDLE is treated as a new request.
- Picker rules:
  - Fixed mode: the lowest pending index wins.
  - RR mode: the first pending index found searching upward from rr_ptr, wrapping modulo NUM_CH.
  - A lone requester always wins regardless of the pointer.
- Simultaneous ch_read and ch_write on one channel: write wins (op_write = 1).
- mem_resp in IDLE is ignored (no ch_resp, no state change).
- busy = (state == BUSY).
- ch_resp is never asserted for more than one channel.

Decomposition:
- lc3b_types additions:
  - arb_state_t enum {ARB_IDLE, ARB_BUSY}.
  - localparam ARB_MAX_CH = 8.
- Sub-module rr_priority_picker:
  - Params: N.
  - Inputs: req[N], ptr, rr_en.
  - Outputs: valid, idx.
  - Purely combinational, giving one reusable search unit.
- Top level holds the FSM, the latches, rr_ptr and the response demux.

Test Plan:
- Reset then idle: rst_n low for 3 cycles, all requests low -> mem_read = mem_write = 0, busy = 0, ch_resp = 0, grant_id = 0.
- Single read: ch_read = 01, ch_addr[0] = 16'h1234, mem_resp after 4 cycles with mem_rdata = 128'hA5... -> mem_read high from cycle 1, mem_addr = 1234, ch_resp = 01 in the resp cycle, ch_rdata = A5...
- Contention, fixed mode (RR_MODE = 0): ch_read held = 11 continuously -> channel 0 is granted every time and channel 1 starves (expected in this mode).
- Contention, round-robin (NUM_CH = 4, RR_MODE = 1): all four channels hold requests -> grant order 0, 1, 2, 3, 0.
- Round-robin lone requester: only channel 2 requests while rr_ptr = 3 -> channel 2 is granted.
- Latching, simultaneous ops and reset:
  - D-cache write at address 16'h0040 with a data pattern; ch_addr[1] changes to 16'h9999 mid-BUSY -> mem_addr stays 0040 and mem_write stays held.
  - ch_read and ch_write both high on one channel -> mem_write.
  - rst_n pulsed low mid-BUSY -> strobes drop asynchronously, no ch_resp.
